ps2_atom_keyboard: RTL and testbench

PS2_ATOM_KEYBOARD -- requirements
Module: ps2_atom_keyboard

---
 rtl/ps2_atom_pkg.sv | 63 ++++++
 rtl/ps2_rx.sv | 116 +++++++++++
 rtl/ps2_atom_keyboard.sv | 113 +++++++++++
 tb/tb_ps2_atom_keyboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_atom_pkg.sv
// Shared types, scan-code constants and the PS/2 set-2 to Atom matrix keymap.
package ps2_atom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_REPT   = 8'h11;
  localparam logic [7:0] SC_BREAK  = 8'h07;

  localparam int KEY_ROWS = 10;
  localparam int KEY_COLS = 6;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } key_entry_t;

  // Indexed by {ext, scancode}.
  typedef key_entry_t [511:0] keymap_t;

  function automatic key_entry_t km(input int row, input int col);
    key_entry_t e;
    e.valid = 1'b1;
    e.row   = 4'(row);
    e.col   = 3'(col);
    return e;
  endfunction

  function automatic keymap_t build_keymap();
    keymap_t m;
    m = '0;
    m[9'h045] = km(0, 0);  m[9'h016] = km(1, 4);  m[9'h01E] = km(1, 3);
    m[9'h026] = km(1, 2);  m[9'h025] = km(1, 1);  m[9'h02E] = km(1, 0);
    m[9'h036] = km(2, 5);  m[9'h03D] = km(2, 4);  m[9'h03E] = km(2, 3);
    m[9'h046] = km(2, 2);  m[9'h01C] = km(3, 2);  m[9'h032] = km(3, 1);
    m[9'h021] = km(3, 0);  m[9'h023] = km(4, 5);  m[9'h024] = km(4, 4);
    m[9'h02B] = km(4, 3);  m[9'h034] = km(4, 2);  m[9'h033] = km(4, 1);
    m[9'h043] = km(4, 0);  m[9'h03B] = km(5, 5);  m[9'h042] = km(5, 4);
    m[9'h04B] = km(5, 3);  m[9'h03A] = km(6, 5);  m[9'h031] = km(6, 4);
    m[9'h044] = km(6, 3);  m[9'h04D] = km(6, 2);  m[9'h05A] = km(6, 1);
    m[9'h066] = km(6, 0);  m[9'h015] = km(7, 5);  m[9'h02D] = km(7, 4);
    m[9'h01B] = km(7, 3);  m[9'h02C] = km(7, 2);  m[9'h03C] = km(8, 5);
    m[9'h02A] = km(8, 4);  m[9'h01D] = km(8, 3);  m[9'h022] = km(8, 2);
    m[9'h035] = km(8, 1);  m[9'h01A] = km(8, 0);  m[9'h029] = km(9, 0);
    // Extended cursor keys.
    m[9'h175] = km(9, 5);  m[9'h172] = km(9, 4);  m[9'h16B] = km(9, 3);
    m[9'h174] = km(9, 2);
    return m;
  endfunction

  localparam keymap_t KEYMAP = build_keymap();

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter the clock, deframe
// 11-bit frames and abandon frames that stall.
module ps2_rx
  import ps2_atom_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]          clk_sync_q, data_sync_q;
  logic [FILT_LEN-1:0] samp_q;
  logic                filt_q, filt_d;
  logic                strobe;

  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic [TW-1:0] tmo_q;
  logic [7:0] byte_q;
  logic       valid_q, err_q;

  // The filtered clock only moves once the whole sample window agrees.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    filt_d = filt_q;
    if (&samp_q)       filt_d = 1'b1;
    else if (~|samp_q) filt_d = 1'b0;
  end

  assign strobe = filt_q & ~filt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      samp_q      <= '1;
      filt_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      samp_q      <= (samp_q << 1) | FILT_LEN'(clk_sync_q[1]);
      filt_q      <= filt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q != ST_IDLE && !strobe && tmo_q == TMO_LAST) begin
        state_q <= ST_IDLE;
        tmo_q   <= '0;
        err_q   <= 1'b1;
      end else begin
        if (state_q == ST_IDLE || strobe) tmo_q <= '0;
        else                              tmo_q <= tmo_q + 1'b1;
        if (strobe) begin
          unique case (state_q)
            ST_IDLE: begin
              if (!data_sync_q[1]) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              shift_q <= {data_sync_q[1], shift_q[7:1]};
              if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
              else                   bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            ST_PARITY: begin
              par_q   <= data_sync_q[1];
              state_q <= ST_STOP;
            end
            ST_STOP: begin
              state_q <= ST_IDLE;
              if ((^{shift_q, par_q}) && data_sync_q[1]) begin
                byte_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ps2_atom_keyboard.sv
// PS/2 keyboard to Acorn Atom PIA matrix adapter: prefix decode, key state
// and the active-low row/column output mux.
module ps2_atom_keyboard
  import ps2_atom_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] row_sel,
  output logic [7:0] port_b,
  output logic       rept_n,
  output logic       break_n,
  output logic       rx_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILT_LEN      (FILT_LEN)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid),
    .err_o     (rx_err)
  );

  logic [KEY_ROWS-1:0][KEY_COLS-1:0] matrix_q, matrix_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic ctrl_q, ctrl_d, rept_q, rept_d, brk_key_q, brk_key_d;
  key_entry_t entry;
  logic       pressed;
  logic [5:0] col_n;

  always_comb begin
    matrix_d  = matrix_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    ctrl_d    = ctrl_q;
    rept_d    = rept_q;
    brk_key_d = brk_key_q;
    entry     = KEYMAP[{ext_q, rx_byte}];
    pressed   = ~brk_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Both CTRL keys map to one bit; the other specials are base-set only.
        if (rx_byte == SC_CTRL)                   ctrl_d    = pressed;
        else if (!ext_q && rx_byte == SC_LSHIFT)  lshift_d  = pressed;
        else if (!ext_q && rx_byte == SC_RSHIFT)  rshift_d  = pressed;
        else if (!ext_q && rx_byte == SC_REPT)    rept_d    = pressed;
        else if (!ext_q && rx_byte == SC_BREAK)   brk_key_d = pressed;
        else if (entry.valid && entry.row < 4'(KEY_ROWS) && entry.col < 3'(KEY_COLS))
          matrix_d[entry.row][entry.col] = pressed;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the key matrix is plain flops, so it is reset like any register.
      matrix_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      ctrl_q    <= 1'b0;
      rept_q    <= 1'b0;
      brk_key_q <= 1'b0;
    end else begin
      matrix_q  <= matrix_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      ctrl_q    <= ctrl_d;
      rept_q    <= rept_d;
      brk_key_q <= brk_key_d;
    end
  end

  // Rows beyond the matrix read as no keys pressed.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < KEY_ROWS; r++) begin
      if (row_sel == 4'(r)) col_n = ~matrix_q[r];
    end
  end

  assign port_b  = {~(lshift_q | rshift_q), ~ctrl_q, col_n};
  assign rept_n  = ~rept_q;
  assign break_n = ~brk_key_q;

endmodule

// File: tb/tb_ps2_atom_keyboard.sv
// Directed bench: PS/2 frames from a vector table plus hand-written corner sequences.
module tb_ps2_atom_keyboard;

  localparam int TMO      = 300;
  localparam int HALF_BIT = 40;

  logic       clk, reset_n, ps2_clk, ps2_data;
  logic [3:0] row_sel;
  logic [7:0] port_b;
  logic       rept_n, break_n, rx_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;

  ps2_atom_keyboard #(
    .TIMEOUT_CYCLES(TMO),
    .FILT_LEN      (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .row_sel (row_sel),
    .port_b  (port_b),
    .rept_n  (rept_n),
    .break_n (break_n),
    .rx_err  (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rx_err === 1'b1) err_cnt <= err_cnt + 1;

  typedef struct {
    bit         send;
    logic [7:0] code;
    bit         good_par;
    logic [3:0] row;
    logic [7:0] exp_pb;
    logic       exp_rept;
    logic       exp_brk;
    int         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_clks(HALF_BIT / 2);
    ps2_clk = 1'b0;
    wait_clks(HALF_BIT);
    ps2_clk = 1'b1;
    wait_clks(HALF_BIT / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good ? ~^b : ^b);
    ps2_bit(stop);
    ps2_data = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    row_sel = 4'd15;
    #1;
    check({tag, " port_b r15"}, port_b, 8'hFF);
    row_sel = 4'd1;
    #1;
    check({tag, " port_b r1"}, port_b, 8'hFF);
    row_sel = 4'd3;
    #1;
    check({tag, " port_b r3"}, port_b, 8'hFF);
    check({tag, " rept_n"}, rept_n, 1'b1);
    check({tag, " break_n"}, break_n, 1'b1);
    check({tag, " rx_err"}, rx_err, 1'b0);
  endtask

  initial begin
    int e0;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    row_sel  = 4'd0;

    //             send code  par row    port_b rept brk err
    vecs.push_back('{1, 8'h1C, 1, 4'd3,  8'hFB, 1, 1, 0});
    vecs.push_back('{0, 8'h00, 1, 4'd2,  8'hFF, 1, 1, 0});
    vecs.push_back('{1, 8'hF0, 1, 4'd3,  8'hFB, 1, 1, 0});
    vecs.push_back('{1, 8'h1C, 1, 4'd3,  8'hFF, 1, 1, 0});
    vecs.push_back('{1, 8'h12, 1, 4'd15, 8'h7F, 1, 1, 0});
    vecs.push_back('{1, 8'h59, 1, 4'd15, 8'h7F, 1, 1, 0});
    vecs.push_back('{1, 8'hF0, 1, 4'd15, 8'h7F, 1, 1, 0});
    vecs.push_back('{1, 8'h12, 1, 4'd15, 8'h7F, 1, 1, 0});
    vecs.push_back('{1, 8'hF0, 1, 4'd15, 8'h7F, 1, 1, 0});
    vecs.push_back('{1, 8'h59, 1, 4'd15, 8'hFF, 1, 1, 0});
    vecs.push_back('{1, 8'h16, 0, 4'd1,  8'hFF, 1, 1, 1});
    vecs.push_back('{1, 8'h16, 1, 4'd1,  8'hEF, 1, 1, 0});
    vecs.push_back('{1, 8'h16, 1, 4'd1,  8'hEF, 1, 1, 0});
    vecs.push_back('{1, 8'hE0, 1, 4'd15, 8'hFF, 1, 1, 0});
    vecs.push_back('{1, 8'h14, 1, 4'd15, 8'hBF, 1, 1, 0});
    vecs.push_back('{1, 8'h07, 1, 4'd15, 8'hBF, 1, 0, 0});
    vecs.push_back('{1, 8'hF0, 1, 4'd15, 8'hBF, 1, 0, 0});
    vecs.push_back('{1, 8'h07, 1, 4'd15, 8'hBF, 1, 1, 0});

    wait_clks(5);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clks(5);

    foreach (vecs[i]) begin
      e0 = err_cnt;
      if (vecs[i].send) send_frame(vecs[i].code, vecs[i].good_par, 1'b1);
      row_sel = vecs[i].row;
      wait_clks(2);
      check($sformatf("vec%0d port_b", i), port_b, vecs[i].exp_pb);
      check($sformatf("vec%0d rept_n", i), rept_n, vecs[i].exp_rept);
      check($sformatf("vec%0d break_n", i), break_n, vecs[i].exp_brk);
      check($sformatf("vec%0d rx_err pulses", i), err_cnt - e0, vecs[i].exp_err);
    end

    // Output mux follows row_sel combinationally.
    row_sel = 4'd1;
    #1;
    check("mux row1", port_b, 8'hAF);
    row_sel = 4'd2;
    #1;
    check("mux row2", port_b, 8'hBF);

    // Bad stop bit discards the byte.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    row_sel = 4'd3;
    wait_clks(2);
    check("bad stop err", err_cnt - e0, 1);
    check("bad stop row3", port_b, 8'hBF);

    // Stalled frame: start + 4 data bits, then silence past the timeout.
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_clks(TMO + HALF_BIT);
    check("timeout err", err_cnt - e0, 1);
    e0 = err_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    wait_clks(2);
    check("post-timeout rept_n", rept_n, 1'b0);
    check("post-timeout no err", err_cnt - e0, 0);

    // Pending break prefix and live keys are all cleared by reset.
    send_frame(8'hF0, 1'b1, 1'b1);
    wait_clks(2);
    reset_n = 1'b0;
    wait_clks(3);
    check_reset_outputs("mid reset");
    reset_n = 1'b1;
    wait_clks(3);
    e0 = err_cnt;
    send_frame(8'h16, 1'b1, 1'b1);
    row_sel = 4'd1;
    wait_clks(2);
    check("after reset F0 dropped", port_b, 8'hEF);

    // Reset in the middle of a frame, then a clean frame.
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    reset_n = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    ps2_data = 1'b1;
    wait_clks(3);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    row_sel = 4'd3;
    wait_clks(2);
    check("frame after mid-frame reset", port_b, 8'hFB);
    check("no err after mid-frame reset", err_cnt - e0, 0);
    row_sel = 4'd1;
    #1;
    check("row1 cleared by reset", port_b, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
